// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory controller: clears the array after reset, then
// serves one load/store per cycle with a single-cycle registered response.
//
// state   | meaning
// S_CLEAR | zeroing mem[clr_ptr], one word per cycle; requests ignored
// S_RUN   | accepting requests, one per cycle
module data_mem_ctrl #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_clr_ptr;
  logic [31:0]      r_mem [DEPTH];

  logic             w_ready;
  logic             w_accept;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_rd_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_ptr == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_ready = 1'b1;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_ptr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  assign req_ready = w_ready;
  assign init_done = (r_state == S_RUN);
  assign w_accept  = req_valid & w_ready;
  assign w_idx     = req_addr[IDX_W+1:2];
  assign w_lane    = req_addr[1:0];

  // Any address bit above the array span makes the request out of range.
  assign w_err = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (|req_addr[1:0]))
               | (|(req_addr >> (IDX_W + 2)));

  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_rd_word = r_mem[w_idx];
  assign w_byte    = w_rd_word[{w_lane, 3'b000} +: 8];
  assign w_half    = req_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_load = w_rd_word;
    case (req_size)
      2'b00:   w_load = {{24{~req_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~req_unsigned & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= w_accept;
      rsp_err   <= w_accept & w_err;
      rsp_rdata <= (w_accept && !w_err && !req_we) ? w_load : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl at DEPTH=16: directed scenarios plus randomized
// traffic checked against a little-endian byte-array reference model.
module tb_data_mem_ctrl;

  localparam int DEPTH  = 16;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mm [NBYTES];

  data_mem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory is a flat byte array; a request touches 2**size bytes.
  task automatic model_req(input bit we, input logic [31:0] addr, input logic [1:0] size,
                           input bit uns, input logic [31:0] wd,
                           output bit err, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    n   = 1 << size;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= NBYTES);
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[int'(addr) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endtask

  task automatic issue(input string tag, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wd,
                       input bit exp_err, input logic [31:0] exp_rd);
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'h0;
    @(posedge clk);
    #1;
    check(tag, {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'h0);
    check({tag, "_hi"}, 32'(rsp_rdata[31:30]), 32'h0);
  endtask

  // Releases reset with a load held on the request port and times the clear.
  task automatic wait_clear(input string tag);
    int cnt;
    bit seen_rsp;
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_size  = 2'd2;
    reset     = 1'b0;
    cnt       = 0;
    seen_rsp  = 1'b0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rsp_valid) seen_rsp = 1'b1;
      if (req_ready) break;
    end
    check({tag, "_clear_cycles"}, 32'(cnt), 32'(DEPTH));
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
    check({tag, "_no_rsp_in_clear"}, 32'(seen_rsp), 32'd0);
  endtask

  initial begin
    bit          e_err;
    logic [31:0] e_rd;
    bit          r_we;
    bit          r_uns;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wd;

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    #1;
    check("rst_outputs", {rsp_valid, rsp_err, req_ready, init_done}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);

    wait_clear("init");
    issue("ld_after_init_3c", 0, 32'h3C, 2'd2, 0, 0, 0, 32'h0);
    issue("ld_after_init_20", 0, 32'h20, 2'd2, 0, 0, 0, 32'h0);

    issue("st_deadbeef", 1, 32'h8, 2'd2, 0, 32'hDEADBEEF, 0, 32'h0);
    issue("lb_signed_b", 0, 32'hB, 2'd0, 0, 0, 0, 32'hFFFFFFDE);
    issue("lb_unsigned_b", 0, 32'hB, 2'd0, 1, 0, 0, 32'h000000DE);
    issue("lh_signed_8", 0, 32'h8, 2'd1, 0, 0, 0, 32'hFFFFBEEF);
    issue("lh_unsigned_a", 0, 32'hA, 2'd1, 1, 0, 0, 32'h0000DEAD);
    issue("lw_ignores_uns", 0, 32'h8, 2'd2, 1, 0, 0, 32'hDEADBEEF);
    idle("idle_after_loads");

    issue("st_11223344", 1, 32'h4, 2'd2, 0, 32'h11223344, 0, 32'h0);
    issue("sb_5a", 1, 32'h5, 2'd0, 0, 32'hFFFFFF5A, 0, 32'h0);
    issue("lw_merged", 0, 32'h4, 2'd2, 0, 0, 0, 32'h11225A44);
    idle("idle_after_merge");
    issue("sh_hi", 1, 32'h6, 2'd1, 0, 32'hAAAA8001, 0, 32'h0);
    issue("lw_sh_hi", 0, 32'h4, 2'd2, 0, 0, 0, 32'h80015A44);

    issue("err_lw_6", 0, 32'h6, 2'd2, 0, 0, 1, 32'h0);
    issue("err_lh_3", 0, 32'h3, 2'd1, 0, 0, 1, 32'h0);
    issue("err_size3", 0, 32'h0, 2'd3, 0, 0, 1, 32'h0);
    issue("err_lw_40", 0, 32'h40, 2'd2, 0, 0, 1, 32'h0);
    issue("err_lb_hibit", 0, 32'h8000_0008, 2'd0, 0, 0, 1, 32'h0);
    issue("err_sw_40", 1, 32'h40, 2'd2, 0, 32'hFFFFFFFF, 1, 32'h0);
    issue("lw0_unchanged", 0, 32'h0, 2'd2, 0, 0, 0, 32'h0);
    issue("err_sw_misal", 1, 32'h9, 2'd2, 0, 32'h0, 1, 32'h0);
    issue("lw8_unchanged", 0, 32'h8, 2'd2, 0, 0, 0, 32'hDEADBEEF);

    issue("b2b_st0", 1, 32'h10, 2'd2, 0, 32'hCAFEF00D, 0, 32'h0);
    issue("b2b_ld0", 0, 32'h10, 2'd2, 0, 0, 0, 32'hCAFEF00D);
    issue("b2b_st1", 1, 32'h14, 2'd2, 0, 32'h01234567, 0, 32'h0);
    issue("b2b_ld1", 0, 32'h14, 2'd2, 0, 0, 0, 32'h01234567);
    idle("idle_after_b2b");

    issue("mid_st", 1, 32'h20, 2'd2, 0, 32'h55AA55AA, 0, 32'h0);
    issue("mid_ld", 0, 32'h20, 2'd2, 0, 0, 0, 32'h55AA55AA);
    reset = 1'b1;
    #1;
    check("mid_rst_outputs", {rsp_valid, rsp_err, req_ready, init_done}, 32'h0);
    check("mid_rst_rdata", rsp_rdata, 32'h0);
    wait_clear("rerun");
    issue("after_rst_10", 0, 32'h10, 2'd2, 0, 0, 0, 32'h0);
    issue("after_rst_20", 0, 32'h20, 2'd2, 0, 0, 0, 32'h0);
    issue("after_rst_8", 0, 32'h8, 2'd2, 0, 0, 0, 32'h0);

    for (int i = 0; i < NBYTES; i++) mm[i] = 8'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle("rnd_idle");
      end else begin
        r_we   = 1'($urandom_range(0, 1));
        r_uns  = 1'($urandom_range(0, 1));
        r_addr = 32'($urandom_range(0, NBYTES - 1));
        if ($urandom_range(0, 9) == 0) r_addr = r_addr | (32'h1 << $urandom_range(6, 31));
        r_size = 2'($urandom_range(0, 3));
        if (r_size == 2'd3 && $urandom_range(0, 3) != 0) r_size = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 2) != 0) begin
          if (r_size == 2'd1) r_addr[0] = 1'b0;
          if (r_size == 2'd2) r_addr[1:0] = 2'b00;
        end
        r_wd = $urandom;
        model_req(r_we, r_addr, r_size, r_uns, r_wd, e_err, e_rd);
        issue("rnd", r_we, r_addr, r_size, r_uns, r_wd, e_err, e_rd);
      end
    end
    idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
